// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, reset/bubble constants,
// base opcodes and the IF/ID pipeline register layout.
package rv32i_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with +4 increment, redirect/stall selection and a
// registered flag for redirect targets that are not word aligned.
module pc_reg #(
   parameter int              XLEN     = rv32i_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = rv32i_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_stall,
   input  logic            i_br_taken,
   input  logic [XLEN-1:0] i_br_target,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc4,
   output logic            o_misalign
);

   logic [XLEN-1:0] r_pc;
   logic            r_misalign;
   logic [XLEN-1:0] w_pc4;
   logic [XLEN-1:0] w_target;

   // Adder wraps modulo 2^XLEN; the low target bits are dropped, not trapped.
   assign w_pc4    = r_pc + XLEN'(4);
   assign w_target = {i_br_target[XLEN-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= i_br_taken && (i_br_target[1:0] != 2'b00);
         if (i_br_taken)
            r_pc <= w_target;
         else if (!i_stall)
            r_pc <= w_pc4;
      end
   end

   assign o_pc       = r_pc;
   assign o_pc4      = w_pc4;
   assign o_misalign = r_misalign;

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: presents the PC to a combinational imem,
// captures instr/pc/pc+4 for decode, and counts valid fetches.
module fetch_stage #(
   parameter int              XLEN      = rv32i_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = rv32i_pkg::RESET_PC,
   parameter logic [31:0]     NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] br_target_i,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [31:0]     imem_rdata_i,
   output logic [31:0]     if_id_instr_o,
   output logic [XLEN-1:0] if_id_pc_o,
   output logic [XLEN-1:0] if_id_pc4_o,
   output logic            if_id_valid_o,
   output logic            misalign_o,
   output logic [31:0]     fetch_cnt_o
);

   import rv32i_pkg::if_id_t;

   logic [XLEN-1:0] w_pc;
   logic [XLEN-1:0] w_pc4;
   if_id_t          r_if_id;
   logic [31:0]     r_fetch_cnt;

   pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .rst         (rst),
      .i_stall     (stall_i),
      .i_br_taken  (br_taken_i),
      .i_br_target (br_target_i),
      .o_pc        (w_pc),
      .o_pc4       (w_pc4),
      .o_misalign  (misalign_o)
   );

   // if_id_valid_o qualifies the IF/ID contents each cycle: 1 means decode
   // must consume the word, 0 means a bubble. There is no ready; back-pressure
   // comes only through stall_i, which freezes PC and IF/ID together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_if_id     <= '{instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};
         r_fetch_cnt <= 32'd0;
      end else if (flush_i) begin
         // Bubble still records the PC it displaced, which helps debug traces.
         r_if_id <= '{instr: NOP_INSTR, pc: w_pc, pc4: w_pc4, valid: 1'b0};
      end else if (!stall_i) begin
         r_if_id     <= '{instr: imem_rdata_i, pc: w_pc, pc4: w_pc4, valid: 1'b1};
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end

   assign imem_addr_o   = w_pc;
   assign if_id_instr_o = r_if_id.instr;
   assign if_id_pc_o    = r_if_id.pc;
   assign if_id_pc4_o   = r_if_id.pc4;
   assign if_id_valid_o = r_if_id.valid;
   assign fetch_cnt_o   = r_fetch_cnt;

endmodule
